dw_norm_rnd_pipe: RTL

//  Pipelined, back-pressured normalise-and-round unit for sign-magnitude values: leading-one search,

---
 rtl/dw_norm_rnd_pipe.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dw_norm_rnd_pipe.sv
// dw_norm_rnd_pipe: three-stage normalise-and-round pipeline for sign-magnitude values.
// Stage 1 finds the leading one, stage 2 shifts and adjusts the exponent, stage 3 rounds.
// A single advance signal moves every stage at once, so bubbles travel and never collapse.
module dw_norm_rnd_pipe #(
   parameter int unsigned A_WIDTH   = 16,
   parameter int unsigned SRCH_WIND = 4,
   parameter int unsigned EXP_WIDTH = 4,
   parameter int unsigned B_WIDTH   = 10,
   parameter bit          EXP_CTR   = 1'b0,
   parameter int unsigned TAG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [A_WIDTH-1:0]   a_mag,
   input  logic                 a_sign,
   input  logic [EXP_WIDTH-1:0] pos_offset,
   input  logic                 sticky_bit,
   input  logic [2:0]           rnd_mode,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [B_WIDTH-1:0]   b,
   output logic [EXP_WIDTH-1:0] pos,
   output logic                 no_detect,
   output logic                 pos_err,
   output logic                 out_sign,
   output logic [TAG_WIDTH-1:0] out_tag
);

   localparam int unsigned N_W = $clog2(A_WIDTH + 1);
   localparam int unsigned PW  = EXP_WIDTH + 1;
   localparam int unsigned BW1 = B_WIDTH + 1;
   // Round bit sits just below the kept mantissa; everything below it feeds sticky.
   localparam int                 RB_IDX  = int'(A_WIDTH) - int'(B_WIDTH) - 1;
   localparam logic [A_WIDTH-1:0] RB_MASK = (RB_IDX >= 0) ? (A_WIDTH'(1) << RB_IDX) : '0;
   localparam logic [A_WIDTH-1:0] LO_MASK = (RB_IDX > 0) ? (RB_MASK - A_WIDTH'(1)) : '0;

   logic adv;

   // Stage 1 registers
   logic                 s1_valid;
   logic [A_WIDTH-1:0]   s1_mag;
   logic [N_W-1:0]       s1_n;
   logic                 s1_nd;
   logic                 s1_sign;
   logic [EXP_WIDTH-1:0] s1_off;
   logic                 s1_sticky;
   logic [2:0]           s1_mode;
   logic [TAG_WIDTH-1:0] s1_tag;

   // Stage 2 registers
   logic                 s2_valid;
   logic [A_WIDTH-1:0]   s2_m;
   logic [EXP_WIDTH-1:0] s2_pos1;
   logic                 s2_e1;
   logic                 s2_nd;
   logic                 s2_sign;
   logic                 s2_sticky;
   logic [2:0]           s2_mode;
   logic [TAG_WIDTH-1:0] s2_tag;

   // Combinational stage results
   logic [N_W-1:0]       lz_c;
   logic                 found_c;
   logic [N_W-1:0]       n_c;
   logic [A_WIDTH-1:0]   m_c;
   logic [PW-1:0]        pos1_c;
   logic [B_WIDTH-1:0]   res_c;
   logic                 rb_c;
   logic                 st_c;
   logic                 inc_c;
   logic [BW1-1:0]       sum_c;
   logic                 co_c;
   logic [PW-1:0]        step_c;
   logic [B_WIDTH-1:0]   b_c;
   logic [EXP_WIDTH-1:0] pos_c;
   logic                 err_c;

   // Whole pipe advances when the output slot is empty or being drained.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // Leading-zero count over the search window, MSB downward.
   always_comb begin
      lz_c    = '0;
      found_c = 1'b0;
      for (int i = 0; i < int'(SRCH_WIND); i++) begin
         if (!found_c) begin
            if (a_mag[int'(A_WIDTH) - 1 - i]) found_c = 1'b1;
            else                              lz_c    = lz_c + N_W'(1);
         end
      end
      n_c = found_c ? lz_c : N_W'(SRCH_WIND - 1);
   end

   // Stage 1 register: capture operands and shift amount.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_mag    <= '0;
         s1_n      <= '0;
         s1_nd     <= 1'b0;
         s1_sign   <= 1'b0;
         s1_off    <= '0;
         s1_sticky <= 1'b0;
         s1_mode   <= '0;
         s1_tag    <= '0;
      end else if (adv) begin
         s1_valid  <= in_valid;
         s1_mag    <= a_mag;
         s1_n      <= n_c;
         s1_nd     <= ~found_c;
         s1_sign   <= a_sign;
         s1_off    <= pos_offset;
         s1_sticky <= sticky_bit;
         s1_mode   <= rnd_mode;
         s1_tag    <= in_tag;
      end
   end

   // Normalising shift and first exponent adjust; the extra bit is the carry/borrow.
   always_comb begin
      m_c = s1_mag << s1_n;
      if (EXP_CTR) pos1_c = {1'b0, s1_off} - PW'(s1_n);
      else         pos1_c = {1'b0, s1_off} + PW'(s1_n);
   end

   // Stage 2 register: shifted mantissa and provisional position.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_m      <= '0;
         s2_pos1   <= '0;
         s2_e1     <= 1'b0;
         s2_nd     <= 1'b0;
         s2_sign   <= 1'b0;
         s2_sticky <= 1'b0;
         s2_mode   <= '0;
         s2_tag    <= '0;
      end else if (adv) begin
         s2_valid  <= s1_valid;
         s2_m      <= m_c;
         s2_pos1   <= pos1_c[EXP_WIDTH-1:0];
         s2_e1     <= pos1_c[EXP_WIDTH];
         s2_nd     <= s1_nd;
         s2_sign   <= s1_sign;
         s2_sticky <= s1_sticky;
         s2_mode   <= s1_mode;
         s2_tag    <= s1_tag;
      end
   end

   // Rounding increment, mantissa overflow renormalise and second exponent adjust.
   always_comb begin
      res_c = s2_m[A_WIDTH-1 -: B_WIDTH];
      rb_c  = |(s2_m & RB_MASK);
      st_c  = s2_sticky | (|(s2_m & LO_MASK));
      case (s2_mode)
         3'b000:         inc_c = rb_c & (st_c | res_c[0]);
         3'b010:         inc_c = ~s2_sign & (rb_c | st_c);
         3'b011:         inc_c = s2_sign & (rb_c | st_c);
         3'b100, 3'b110: inc_c = rb_c;
         3'b101:         inc_c = rb_c | st_c;
         default:        inc_c = 1'b0;
      endcase
      sum_c = {1'b0, res_c} + BW1'(inc_c);
      co_c  = sum_c[B_WIDTH];
      b_c   = co_c ? {1'b1, sum_c[B_WIDTH-1:1]} : sum_c[B_WIDTH-1:0];
      if (EXP_CTR) step_c = {1'b0, s2_pos1} + PW'(1);
      else         step_c = {1'b0, s2_pos1} - PW'(1);
      pos_c = co_c ? step_c[EXP_WIDTH-1:0] : s2_pos1;
      err_c = s2_e1 | (co_c & step_c[EXP_WIDTH]);
   end

   // Output register: held stable while the result waits for out_ready.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         b         <= '0;
         pos       <= '0;
         no_detect <= 1'b0;
         pos_err   <= 1'b0;
         out_sign  <= 1'b0;
         out_tag   <= '0;
      end else if (adv) begin
         out_valid <= s2_valid;
         b         <= b_c;
         pos       <= pos_c;
         no_detect <= s2_nd;
         pos_err   <= err_c;
         out_sign  <= s2_sign;
         out_tag   <= s2_tag;
      end
   end

endmodule
